spi_master_controller: RTL and testbench
========================================

Name: spi_master_controller

Overview:
- SPI/QPI host-side transaction engine that drives the slave controller's CMD -> ADDR -> DUMMY -> DATA protocol from the system side.
- Accepts one request (command, optional address, dummy count, read/write data) and serialises it MSB-first on standard (1-bit) or quad (4-bit) lanes.
- Returns read data on a single-cycle response pulse.
- Used by bench masters and by SoCs that talk to an SPI slave port.

Parameters:
CLK_DIV, 2, system clocks per SPI clock half-period; legal range 1..255.

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  engine idle, can accept; transfer occurs when req_valid & req_ready
req_cmd  in  8  command byte
req_use_addr  in  1  1 = send the address phase
req_addr  in  32  address
req_dummy  in  8  dummy SPI clocks; 0 = no dummy phase
req_rd  in  1  1 = read 32-bit data word, 0 = write req_wdata
req_wdata  in  32  write data
req_quad  in  1  1 = quad lanes for all phases of this request
rsp_valid  out  1  one-cycle pulse at end of transaction
rsp_rdata  out  32  read data; valid with rsp_valid, holds until the next rsp_valid
busy  out  1  transaction in progress (~req_ready)
spi_sclk  out  1  SPI clock, mode 0 (idle low)
spi_csn  out  1  chip select, active low
spi_sdo  out  4  output lanes; std mode uses bit 0 only
spi_oe  out  4  per-lane output enable
spi_sdi  in  4  input lanes; std mode samples bit 1

Behaviour:
- Reset values (asynchronous, immediate):
  - req_ready = 1, busy = 0, rsp_valid = 0, rsp_rdata = 0
  - spi_csn = 1, spi_sclk = 0, spi_sdo = 0, spi_oe = 0
  - FSM in IDLE
- Reset mid-transaction aborts immediately: no rsp_valid, csn high.
- Request capture:
  - On handshake, all req_* fields are registered.
  - req_ready drops the next cycle and stays low until the end of the IDLE gap.
  - Inputs are ignored while busy.
- FSM states: IDLE, SETUP, CMD, ADDR, DUMMY, DATA_TX, DATA_RX, HOLD, GAP.
  - IDLE -> SETUP on handshake.
  - SETUP: csn low and first command bit driven for CLK_DIV cycles with sclk low.
  - Phase order: CMD -> ADDR (if req_use_addr) -> DUMMY (if req_dummy != 0) -> DATA_RX if req_rd, else DATA_TX -> HOLD.
  - HOLD: sclk low for CLK_DIV cycles after the last falling edge, then csn high.
  - GAP: csn high for CLK_DIV cycles, then IDLE with req_ready = 1.
- SPI timing:
  - sclk toggles every CLK_DIV sys_clk cycles, so one SPI clock = 2*CLK_DIV cycles.
  - Outputs change only on falling-edge ticks (or on SETUP entry).
  - spi_sdi is sampled on the sys_clk cycle that raises sclk.
- Edge counts (rising edges per phase):
  - CMD: 8 std / 2 quad
  - ADDR: 32 std / 8 quad
  - DUMMY: req_dummy
  - DATA: 32 std / 8 quad
- Phase change happens on the falling edge that follows a phase's last rising edge; there is no extra idle clock between phases.
- Lane mapping:
  - Std: sdo[0] = current bit, MSB first.
  - Quad: sdo[3:0] = current nibble, bits [31:28] first (cmd bits [7:4] first).
  - Rx std shifts in sdi[1]; rx quad shifts in sdi[3:0] nibbles, MSB nibble first.
- Output enables:
  - Std: spi_oe = 4'b0001 for the whole csn-low window.
  - Quad: 4'b1111 during CMD/ADDR/DATA_TX; 4'b0000 during DUMMY, DATA_RX and HOLD.
  - spi_oe = 0 while csn high.
  - spi_sdo = 0 whenever the corresponding oe bit is 0.
- Response:
  - rsp_valid pulses exactly once, in the cycle csn returns high, for both reads and writes.
  - rsp_rdata updates only on reads, at that pulse.
  - A write leaves rsp_rdata unchanged.
- Counters: shift counter is 6 bits; dummy counter is 8 bits. Counters reload at each phase entry and never wrap within a phase.
- A back-to-back request, asserted in the same cycle req_ready rises, is accepted that cycle. The minimum csn-high time is CLK_DIV+1 cycles.

Test Plan:
- Std write (CLK_DIV=2, cmd 0x02, addr 0x1C00_0000, no dummy, wdata 0xDEADBEEF):
  - 72 sclk rises; sdo[0] bit sequence 0x02, then the addr, then the data; oe = 0001.
  - rsp_valid once; csn low for exactly 72*4+2+2 cycles.
- Std read (cmd 0x0B, addr 0x10, dummy 32, sdi[1] driven with 0xA5A5_5A5A on falling edges):
  - rsp_rdata = 0xA5A55A5A; 104 sclk rises.
- Quad read (req_quad=1, dummy 8, sdi nibbles 0x1234_5678):
  - oe 1111 for 10 rises, 0000 for 16 rises; rsp_rdata = 0x12345678.
- Register-style request (use_addr=0, dummy=0, cmd 0x11, std write wdata 0x0000_0001):
  - 8 cmd bits then 32 data bits, no address.
- sys_rstn pulsed low mid-ADDR:
  - csn = 1, sclk = 0, oe = 0 immediately; no rsp_valid.
  - A fresh request afterwards completes normally.
- Back-to-back requests, req_valid held high; req_* changed while busy:
  - second transaction starts CLK_DIV+1 cycles after the first csn rise; changes made while busy are ignored.

Source files
------------

// File: rtl/spi_master_controller.sv
// SPI/QPI host transaction engine. It serialises CMD -> ADDR -> DUMMY -> DATA MSB-first on one
// or four lanes in SPI mode 0 and returns the read word on a single-cycle response pulse.
module spi_master_controller #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic        req_use_addr,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_dummy,
  input  logic        req_rd,
  input  logic [31:0] req_wdata,
  input  logic        req_quad,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_csn,
  output logic [3:0]  spi_sdo,
  output logic [3:0]  spi_oe,
  input  logic [3:0]  spi_sdi
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StSetup, StCmd, StAddr, StDummy, StDataTx, StDataRx, StHold, StGap
  } state_e;

  // Lane value for the MSB beat of a left-aligned shift word.
  function automatic logic [3:0] lanes(input logic [31:0] word, input logic quad);
    return quad ? word[31:28] : {3'b000, word[31]};
  endfunction

  state_e          state_q, state_d;
  state_e          nxt, data_st;
  logic [DivW-1:0] div_q, div_d;
  logic            sclk_q, sclk_d;
  logic            csn_q, csn_d;
  logic [3:0]      sdo_q, sdo_d;
  logic [3:0]      oe_q, oe_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [7:0]      dcnt_q, dcnt_d;
  logic [31:0]     tx_q, tx_d;
  logic [31:0]     rx_q, rx_d;
  logic            use_addr_q, use_addr_d;
  logic [31:0]     addr_q, addr_d;
  logic [7:0]      dummy_q, dummy_d;
  logic            rd_q, rd_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            quad_q, quad_d;
  logic            tick;
  logic            last;
  logic [5:0]      word_beats;
  logic [3:0]      out_oe;
  logic [3:0]      in_oe;

  assign tick       = (div_q == DivLast);
  assign last       = (state_q == StDummy) ? (dcnt_q == 8'd0) : (cnt_q == 6'd0);
  assign word_beats = quad_q ? 6'd8 : 6'd32;
  assign out_oe     = quad_q ? 4'hF : 4'h1;
  // Quad lanes turn around for dummy/read; std keeps lane 0 driven for the whole frame.
  assign in_oe      = quad_q ? 4'h0 : 4'h1;

  always_comb begin
    data_st = rd_q ? StDataRx : StDataTx;
    nxt     = StHold;
    unique case (state_q)
      StCmd: begin
        if (use_addr_q)             nxt = StAddr;
        else if (dummy_q != 8'd0)   nxt = StDummy;
        else                        nxt = data_st;
      end
      StAddr: begin
        if (dummy_q != 8'd0) nxt = StDummy;
        else                 nxt = data_st;
      end
      StDummy: nxt = data_st;
      default: nxt = StHold;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    csn_d       = csn_q;
    sdo_d       = sdo_q;
    oe_d        = oe_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    use_addr_d  = use_addr_q;
    addr_d      = addr_q;
    dummy_d     = dummy_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    quad_d      = quad_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          state_d     = StSetup;
          div_d       = '0;
          csn_d       = 1'b0;
          req_ready_d = 1'b0;
          use_addr_d  = req_use_addr;
          addr_d      = req_addr;
          dummy_d     = req_dummy;
          rd_d        = req_rd;
          wdata_d     = req_wdata;
          quad_d      = req_quad;
          tx_d        = {req_cmd, 24'h0};
          cnt_d       = req_quad ? 6'd2 : 6'd8;
          oe_d        = req_quad ? 4'hF : 4'h1;
          sdo_d       = lanes({req_cmd, 24'h0}, req_quad);
        end
      end

      StSetup: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d   = '0;
          state_d = StCmd;
        end
      end

      StCmd, StAddr, StDummy, StDataTx, StDataRx: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (state_q == StDummy) dcnt_d = dcnt_q - 8'd1;
            else                    cnt_d  = cnt_q - 6'd1;
            if (state_q == StDataRx) begin
              rx_d = quad_q ? {rx_q[27:0], spi_sdi} : {rx_q[30:0], spi_sdi[1]};
            end
          end else if (!last) begin
            if (state_q inside {StCmd, StAddr, StDataTx}) begin
              tx_d  = quad_q ? {tx_q[27:0], 4'h0} : {tx_q[30:0], 1'b0};
              sdo_d = lanes(tx_d, quad_q);
            end
          end else begin
            // Falling edge after the phase's last beat: enter the next phase directly.
            state_d = nxt;
            unique case (nxt)
              StAddr: begin
                tx_d  = addr_q;
                cnt_d = word_beats;
                oe_d  = out_oe;
                sdo_d = lanes(addr_q, quad_q);
              end
              StDummy: begin
                dcnt_d = dummy_q;
                oe_d   = in_oe;
                sdo_d  = 4'h0;
              end
              StDataTx: begin
                tx_d  = wdata_q;
                cnt_d = word_beats;
                oe_d  = out_oe;
                sdo_d = lanes(wdata_q, quad_q);
              end
              StDataRx: begin
                rx_d  = '0;
                cnt_d = word_beats;
                oe_d  = in_oe;
                sdo_d = 4'h0;
              end
              default: begin
                oe_d  = in_oe;
                sdo_d = 4'h0;
              end
            endcase
          end
        end
      end

      StHold: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d       = '0;
          state_d     = StGap;
          csn_d       = 1'b1;
          oe_d        = 4'h0;
          sdo_d       = 4'h0;
          rsp_valid_d = 1'b1;
          if (rd_q) rsp_rdata_d = rx_q;
        end
      end

      StGap: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d       = '0;
          state_d     = StIdle;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        div_d       = '0;
        sclk_d      = 1'b0;
        csn_d       = 1'b1;
        oe_d        = 4'h0;
        sdo_d       = 4'h0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= StIdle;
      div_q       <= '0;
      sclk_q      <= 1'b0;
      csn_q       <= 1'b1;
      sdo_q       <= 4'h0;
      oe_q        <= 4'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      use_addr_q  <= 1'b0;
      addr_q      <= '0;
      dummy_q     <= '0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      quad_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      csn_q       <= csn_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      use_addr_q  <= use_addr_d;
      addr_q      <= addr_d;
      dummy_q     <= dummy_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      quad_q      <= quad_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = ~req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign spi_sclk  = sclk_q;
  assign spi_csn   = csn_q;
  assign spi_sdo   = sdo_q;
  assign spi_oe    = oe_q;

endmodule

// File: tb/tb_spi_master_controller.sv
// Scoreboard bench for spi_master_controller: a request-level model pushes the expected per-beat
// lane values and response; a monitor compares them as the DUT presents SPI beats and responses.
`timescale 1ns/1ps
module tb_spi_master_controller;
  localparam int unsigned CLK_DIV = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = '0;
  logic        req_use_addr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_dummy = '0;
  logic        req_rd = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        req_quad = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        spi_sclk;
  logic        spi_csn;
  logic [3:0]  spi_sdo;
  logic [3:0]  spi_oe;
  logic [3:0]  spi_sdi = '0;

  spi_master_controller #(.CLK_DIV(CLK_DIV)) dut (
    .sys_clk     (sys_clk),
    .sys_rstn    (sys_rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_use_addr(req_use_addr),
    .req_addr    (req_addr),
    .req_dummy   (req_dummy),
    .req_rd      (req_rd),
    .req_wdata   (req_wdata),
    .req_quad    (req_quad),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .spi_sclk    (spi_sclk),
    .spi_csn     (spi_csn),
    .spi_sdo     (spi_sdo),
    .spi_oe      (spi_oe),
    .spi_sdi     (spi_sdi)
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0]  cmd;
    logic        use_addr;
    logic [31:0] addr;
    logic [7:0]  dummy;
    logic        rd;
    logic [31:0] wdata;
    logic        quad;
    logic [31:0] sdi_word;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    int          rises;
    int          low;
  } rsp_t;

  logic [3:0]  exp_sdo_q[$];
  logic [3:0]  exp_oe_q[$];
  logic [3:0]  drv_q[$];
  rsp_t        exp_rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = '0;
  bit          gap_check = 1'b0;

  logic        csn_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          rise_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic req_t mk(input logic [7:0] cmd, input logic ua, input logic [31:0] addr,
                              input logic [7:0] dummy, input logic rd, input logic [31:0] wdata,
                              input logic quad, input logic [31:0] sdi_word);
    req_t r;
    r.cmd = cmd; r.use_addr = ua; r.addr = addr; r.dummy = dummy;
    r.rd = rd; r.wdata = wdata; r.quad = quad; r.sdi_word = sdi_word;
    return r;
  endfunction

  function automatic void push_beat(input logic [3:0] sdo, input logic [3:0] oe,
                                    input logic [3:0] sdi);
    exp_sdo_q.push_back(sdo);
    exp_oe_q.push_back(oe);
    drv_q.push_back(sdi);
  endfunction

  // Reference model: per SPI rising edge, the lanes the host must present and the slave drives.
  function automatic void model_push(input req_t r);
    int          step   = r.quad ? 4 : 1;
    logic [31:0] mask   = r.quad ? 32'hF : 32'h1;
    logic [3:0]  out_oe = r.quad ? 4'hF : 4'h1;
    logic [3:0]  in_oe  = r.quad ? 4'h0 : 4'h1;
    int          rises  = 0;
    rsp_t        e;
    for (int b = 8 - step; b >= 0; b -= step) begin
      push_beat(4'((32'(r.cmd) >> b) & mask), out_oe, 4'($urandom));
      rises++;
    end
    if (r.use_addr) begin
      for (int b = 32 - step; b >= 0; b -= step) begin
        push_beat(4'((r.addr >> b) & mask), out_oe, 4'($urandom));
        rises++;
      end
    end
    for (int i = 0; i < int'(r.dummy); i++) begin
      push_beat(4'h0, in_oe, 4'($urandom));
      rises++;
    end
    for (int b = 32 - step; b >= 0; b -= step) begin
      if (r.rd) begin
        logic [3:0] d;
        d = 4'($urandom);
        if (r.quad) d = 4'((r.sdi_word >> b) & 32'hF);
        else        d[1] = r.sdi_word[b];
        push_beat(4'h0, in_oe, d);
      end else begin
        push_beat(4'((r.wdata >> b) & mask), out_oe, 4'($urandom));
      end
      rises++;
    end
    drv_q.push_back(4'($urandom));
    if (r.rd) last_rdata = r.sdi_word;
    e.rdata = last_rdata;
    e.rises = rises;
    e.low   = int'(CLK_DIV) * (2 * rises + 2);
    exp_rsp_q.push_back(e);
  endfunction

  task automatic issue(input req_t r, input bit hold);
    int waited = 0;
    @(negedge sys_clk);
    req_cmd = r.cmd; req_use_addr = r.use_addr; req_addr = r.addr; req_dummy = r.dummy;
    req_rd = r.rd; req_wdata = r.wdata; req_quad = r.quad;
    req_valid = 1'b1;
    while (!req_ready && waited < 5000) begin
      @(negedge sys_clk);
      waited++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    model_push(r);
    @(posedge sys_clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (exp_rsp_q.size() != 0 && waited < 20000) begin
      @(negedge sys_clk);
      waited++;
    end
    check("drain", 64'(exp_rsp_q.size()), 64'd0);
  endtask

  // Monitor / slave model: compares beats and responses, drives spi_sdi after each falling edge.
  initial begin
    rsp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rstn) begin
        csn_prev  = 1'b1;
        sclk_prev = 1'b0;
      end else begin
        if (csn_prev && !spi_csn) begin
          if (gap_check) begin
            check("csn_high_gap", 64'(high_cnt), 64'(CLK_DIV + 1));
            gap_check = 1'b0;
          end
          low_cnt  = 0;
          rise_cnt = 0;
          check("drv_avail_csn", 64'(drv_q.size() > 0), 64'd1);
          if (drv_q.size() > 0) spi_sdi = drv_q.pop_front();
        end
        if (!csn_prev && spi_csn) begin
          high_cnt = 0;
          check("idle_oe", 64'(spi_oe), 64'd0);
          check("idle_sdo", 64'(spi_sdo), 64'd0);
          check("idle_sclk", 64'(spi_sclk), 64'd0);
        end
        if (spi_csn) high_cnt++;
        else         low_cnt++;
        if (!spi_csn && !sclk_prev && spi_sclk) begin
          rise_cnt++;
          check("beat_expected", 64'(exp_sdo_q.size() > 0), 64'd1);
          if (exp_sdo_q.size() > 0) begin
            check("sdo", 64'(spi_sdo), 64'(exp_sdo_q.pop_front()));
            check("oe", 64'(spi_oe), 64'(exp_oe_q.pop_front()));
          end
        end
        if (!spi_csn && sclk_prev && !spi_sclk) begin
          check("drv_avail_fall", 64'(drv_q.size() > 0), 64'd1);
          if (drv_q.size() > 0) spi_sdi = drv_q.pop_front();
        end
        if (rsp_valid) begin
          check("rsp_expected", 64'(exp_rsp_q.size() > 0), 64'd1);
          if (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("sclk_rises", 64'(rise_cnt), 64'(e.rises));
            check("csn_low_cycles", 64'(low_cnt), 64'(e.low));
          end
        end
        csn_prev  = spi_csn;
        sclk_prev = spi_sclk;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t r;
    req_t ra;
    req_t rb;
    repeat (3) @(negedge sys_clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_csn", 64'(spi_csn), 64'd1);
    check("rst_sclk", 64'(spi_sclk), 64'd0);
    check("rst_sdo", 64'(spi_sdo), 64'd0);
    check("rst_oe", 64'(spi_oe), 64'd0);
    sys_rstn = 1'b1;

    issue(mk(8'h02, 1'b1, 32'h1C00_0000, 8'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0), 1'b0);
    issue(mk(8'h0B, 1'b1, 32'h0000_0010, 8'd32, 1'b1, 32'h0, 1'b0, 32'hA5A5_5A5A), 1'b0);
    issue(mk(8'hEB, 1'b1, $urandom, 8'd8, 1'b1, 32'h0, 1'b1, 32'h1234_5678), 1'b0);
    issue(mk(8'h11, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0000_0001, 1'b0, 32'h0), 1'b0);
    issue(mk(8'h38, 1'b1, 32'hCAFE_F00D, 8'd0, 1'b0, 32'h8765_4321, 1'b1, 32'h0), 1'b0);
    wait_drain();

    // Reset in the middle of the address phase.
    issue(mk(8'h03, 1'b1, 32'h0123_4567, 8'd0, 1'b1, 32'h0, 1'b0, 32'hFFFF_0000), 1'b0);
    repeat (45) @(negedge sys_clk);
    #1 sys_rstn = 1'b0;
    #1;
    check("abort_csn", 64'(spi_csn), 64'd1);
    check("abort_sclk", 64'(spi_sclk), 64'd0);
    check("abort_oe", 64'(spi_oe), 64'd0);
    check("abort_sdo", 64'(spi_sdo), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rsp_rdata", 64'(rsp_rdata), 64'd0);
    exp_sdo_q.delete();
    exp_oe_q.delete();
    drv_q.delete();
    exp_rsp_q.delete();
    last_rdata = '0;
    repeat (2) @(negedge sys_clk);
    #1 sys_rstn = 1'b1;
    issue(mk(8'h6B, 1'b1, 32'h0000_0200, 8'd4, 1'b1, 32'h0, 1'b1, 32'h0BAD_F00D), 1'b0);
    wait_drain();

    // Back-to-back with req_valid held; fields scribbled while busy must be ignored.
    ra = mk(8'h32, 1'b1, 32'h00AB_CDEF, 8'd2, 1'b0, 32'h5A5A_0FF0, 1'b1, 32'h0);
    rb = mk(8'h0B, 1'b1, 32'h0000_1234, 8'd3, 1'b1, 32'h0, 1'b0, 32'h6C3A_91E5);
    issue(ra, 1'b1);
    req_cmd = 8'hFF; req_use_addr = 1'b0; req_addr = $urandom; req_dummy = 8'd77;
    req_rd = 1'b1; req_wdata = $urandom; req_quad = 1'b0;
    repeat (20) @(negedge sys_clk);
    gap_check = 1'b1;
    issue(rb, 1'b0);
    wait_drain();

    for (int i = 0; i < 12; i++) begin
      r.cmd      = 8'($urandom);
      r.use_addr = 1'($urandom_range(0, 1));
      r.addr     = $urandom;
      r.dummy    = 8'($urandom_range(0, 6));
      r.rd       = 1'($urandom_range(0, 1));
      r.wdata    = $urandom;
      r.quad     = 1'($urandom_range(0, 1));
      r.sdi_word = $urandom;
      issue(r, 1'b0);
    end
    wait_drain();
    repeat (10) @(negedge sys_clk);
    check("beat_queue_empty", 64'(exp_sdo_q.size()), 64'd0);
    check("drv_queue_empty", 64'(drv_q.size()), 64'd0);
    check("end_req_ready", 64'(req_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
